// File: rtl/tomasulo_pkg.sv
// tomasulo_pkg: shared widths and types for the Tomasulo front end
package tomasulo_pkg;
  localparam int INSTR_W = 16;
  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/queue_ram.sv
// queue_ram: DEPTH x DATA_W storage, synchronous write, combinational read, no reset
module queue_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge CLK) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_queue_param.sv
// instr_queue_param: parametrised in-order instruction FIFO with flush, occupancy count and registered output
module instr_queue_param
  import tomasulo_pkg::*;
#(
  parameter int DATA_W    = INSTR_W,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [CW-1:0]     count
);
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d, rdata;
  logic              dout_valid_q, dout_valid_d;
  logic              pop_ok, push_ok;
  assign full        = count_q == CW'(DEPTH);
  assign empty       = count_q == '0;
  assign almost_full = count_q >= CW'(AF_THRESH);
  // flush outranks both requests; a pop frees a slot so a full queue still takes the push
  assign pop_ok  = pop & ~empty & ~flush;
  assign push_ok = push & (~full | pop_ok) & ~flush;
  queue_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .CLK  (CLK),
    .we   (push_ok),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  always_comb begin
    wr_ptr_d     = flush ? '0 : wr_ptr_q + AW'(push_ok);
    rd_ptr_d     = flush ? '0 : rd_ptr_q + AW'(pop_ok);
    count_d      = flush ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
    dout_d       = pop_ok ? rdata : dout_q;
    dout_valid_d = pop_ok;
  end
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end
  assign count      = count_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
endmodule

// File: tb/tb_instr_queue_param.sv
// tb_instr_queue_param: directed plus randomized checks against a queue-based reference model
module tb_instr_queue_param;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AF    = DEPTH - 2;
  logic          CLK = 1'b0, CLR = 1'b1, flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid, full, empty, almost_full;
  logic [3:0]    count;
  int            n_tests = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  logic          exp_dv = 1'b0;

  instr_queue_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .CLK(CLK), .CLR(CLR), .flush(flush), .push(push), .din(din), .pop(pop),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("dout_valid", 32'(dout_valid), 32'(exp_dv));
    if (exp_dv) chk("dout", 32'(dout), 32'(exp_dout));
    else chk("dout_hold", 32'(dout), 32'(exp_dout));
  endtask

  task automatic step(input logic f, input logic pu, input logic [DW-1:0] d, input logic po);
    bit pop_ok, push_ok;
    flush = f; push = pu; din = d; pop = po;
    @(posedge CLK);
    if (f) begin
      q.delete();
      exp_dv = 1'b0;
    end else begin
      pop_ok  = po && q.size() > 0;
      push_ok = pu && (q.size() < DEPTH || pop_ok);
      if (pop_ok) exp_dout = q.pop_front();
      exp_dv = pop_ok;
      if (push_ok) q.push_back(d);
    end
    #1;
    check_all();
    flush = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  initial begin
    #2;
    check_all();
    #10 CLR = 1'b0;
    // reset mid-operation
    for (int i = 0; i < 3; i++) step(0, 1, DW'(16'h0A00 + i), 0);
    #3 CLR = 1'b1;
    #1;
    q.delete(); exp_dout = '0; exp_dv = 1'b0;
    check_all();
    #2 CLR = 1'b0;
    step(0, 0, '0, 1);
    // fill, drop on full, drain
    for (int i = 1; i <= 8; i++) step(0, 1, DW'(16'h1000 + i), 0);
    step(0, 1, 16'hDEAD, 0);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, '0, 1);
      chk("drain_order", 32'(dout), 32'(16'h1000 + i));
    end
    // wrap-around rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h2000 + r * 5 + i), 0);
      for (int i = 0; i < 5; i++) step(0, 0, '0, 1);
    end
    // simultaneous push/pop at full
    for (int i = 0; i < 8; i++) step(0, 1, DW'(16'h30 + i), 0);
    step(0, 1, 16'h38, 1);
    chk("full_swap_dout", 32'(dout), 32'h30);
    chk("full_swap_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) step(0, 0, '0, 1);
    // simultaneous push/pop at empty
    step(0, 1, 16'h44, 1);
    chk("empty_swap_dv", 32'(dout_valid), 32'd0);
    step(0, 0, '0, 1);
    chk("empty_swap_dout", 32'(dout), 32'h44);
    // flush with concurrent requests
    for (int i = 0; i < 5; i++) step(0, 1, DW'(16'h50 + i), 0);
    step(1, 1, 16'h55, 1);
    chk("flush_count", 32'(count), 32'd0);
    step(0, 1, 16'h66, 0);
    step(0, 0, '0, 1);
    chk("after_flush", 32'(dout), 32'h66);
    // randomized phases biased toward filling, draining and balanced traffic
    for (int ph = 0; ph < 6; ph++) begin
      int pp, qp;
      pp = (ph % 3 == 0) ? 85 : (ph % 3 == 1) ? 25 : 60;
      qp = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 85 : 60;
      for (int i = 0; i < 300; i++)
        step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < pp, DW'($urandom), $urandom_range(0, 99) < qp);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_queue_param.md
# instr_queue_param

Parametrised in-order instruction FIFO between the instruction unit and the Tomasulo issue stage; successor to the fixed 8×16 instruction queue. It adds configurable width and depth, a synchronous flush for branch recovery, and an occupancy count with almost-full warning. It also allows simultaneous push/pop when full, and adds a registered, qualified output (`dout_valid`).

## Interface
- `DATA_W`, 16, instruction width in bits
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `AF_THRESH`, DEPTH-2, `almost_full` asserts when count ≥ AF_THRESH; legal range 1..DEPTH
- `CLK`  in  1  clock, rising edge
- `CLR`  in  1  reset, asynchronous, active-high
- `flush`  in  1  synchronous discard of all stored entries
- `push`  in  1  write request for `din`
- `din`  in  DATA_W  instruction from the instruction unit
- `pop`  in  1  read request for the head entry
- `dout`  out  DATA_W  registered head entry from the last accepted pop
- `dout_valid`  out  1  high for the one cycle following an accepted pop
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `almost_full`  out  1  count ≥ AF_THRESH
- `count`  out  clog2(DEPTH)+1  current occupancy

## Operation
- State: storage array `DEPTH`×`DATA_W`; `rd_ptr` and `wr_ptr`, each clog2(DEPTH) bits and wrapping modulo DEPTH; occupancy register `count`.
- Pop acceptance: `pop_ok = pop & ~empty`.
- Push acceptance: `push_ok = push & (~full | pop_ok)`.
- Push and pop when full: both are accepted and `count` is unchanged. The slot freed by the pop receives `din`.
- Push and pop when empty: the push is accepted and the pop is ignored. There is no fall-through bypass.
- Push when full with no pop: the push is dropped. Pointers, storage and `count` are unchanged.
- Pop when empty: ignored. `dout` holds its value and `dout_valid` goes to 0.
- Accepted push: `mem[wr_ptr] <= din` and `wr_ptr` increments.
- Accepted pop: `dout <= mem[rd_ptr]`, `dout_valid <= 1` and `rd_ptr` increments.
- Count update: `count` changes by +1, −1 or 0 according to `push_ok` and `pop_ok`.
- Flush (highest synchronous priority):
  - Pointers and `count` go to 0 and `dout_valid` goes to 0.
  - Any push or pop presented in the same cycle is ignored.
  - `dout` holds its value.
  - Storage contents are not cleared.
- Flags: `full`, `empty` and `almost_full` are combinational decodes of `count` only, so they are glitch-free relative to the request inputs.
- Reset (`CLR`): pointers, `count`, `dout` and `dout_valid` go to 0, so `empty` = 1, `full` = 0 and `almost_full` = 0. Storage is not reset. `CLR` mid-operation discards all contents immediately, independent of `CLK`.

## Timing
- All state updates occur on the rising edge of `CLK`. `CLR` acts asynchronously.
- Pop latency: for a pop accepted at edge N, `dout` and `dout_valid` are valid from after edge N until edge N+1.
- Push-to-pop: for a push accepted at edge N, `empty` deasserts after N. The earliest accepted pop of that entry is at edge N+1, with data visible after N+1.
- Flags and `count` reflect the post-edge state in the same cycle.
- Producer handshake: sample `full` (or `almost_full`) in the cycle the push is presented.
- Consumer handshake: qualify `dout` with `dout_valid` only.
- Sustained operation: one push and one pop per cycle at any occupancy, including full. Throughput is 1 entry/cycle.

## Structure
- Shared package `tomasulo_pkg`: `INSTR_W = 16` constant and the `instr_t` typedef. `DATA_W` defaults to `INSTR_W` at instantiation sites.
- Pointer width is derived locally as `AW = $clog2(DEPTH)`; `count` width is `AW+1`.
- One sub-module, `queue_ram`: a `DEPTH`×`DATA_W` array with a synchronous write port and a combinational read port, with no reset so it infers memory. Control, pointers and the output register stay in the top module.

## Test plan
- Reset/idle: assert `CLR` mid-cycle with 3 entries stored → immediately `count` = 0, `empty` = 1, `dout_valid` = 0, `dout` = 0. A following pop is ignored.
- Fill/drain with DEPTH=8: push 0x1001..0x1008 → `full` = 1 and `count` = 8 after the 8th edge, and `almost_full` first at count 6. A 9th push of 0xDEAD is dropped. Eight pops return 0x1001..0x1008 in order, each with `dout_valid`; `empty` = 1 afterwards.
- Wrap-around: repeat push 5 / pop 5 three times (values 0x2000+i) → order preserved across the pointer wrap, and `count` returns to 0 each round.
- Simultaneous at full: with the queue full of 0x30..0x37, push 0x38 and pop together → `dout` = 0x30 and `count` stays 8. Draining then yields 0x31..0x38.
- Simultaneous at empty: push 0x44 and pop together → `dout_valid` = 0 and `count` = 1. The next pop gives `dout` = 0x44.
- Flush: with 5 entries stored, assert `flush` together with push 0x55 and pop → `count` = 0, `dout_valid` = 0, `dout` unchanged. The next push/pop of 0x66 returns 0x66.
